// File: rtl/core_pkg.sv
// Shared types and constants for the 16-bit core's decode-side hazard logic.
// Destination fields are carried at a fixed width so one entry type serves every register-count configuration.
package core_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int RW_DEF       = $clog2(NUM_REGS_DEF);
  localparam int RD_W         = 8;

  localparam int FWD_NONE = 0;
  localparam int FWD_FULL = 1;

  typedef logic [RD_W-1:0] sb_rd_t;

  typedef struct packed {
    logic   v;
    sb_rd_t rd;
    logic   ld;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Compares one decode source against the in-flight slots.
// Only slots inside the hazard window for the selected forwarding mode are considered.
module sb_match
  import core_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = FWD_NONE,
  parameter int RF_BYPASS = 1
) (
  input  logic                  src_vld,
  input  sb_rd_t                src,
  input  sb_entry_t [DEPTH-1:0] slots,
  output logic                  hit
);

  logic [DEPTH-1:0] in_win;
  logic [DEPTH-1:0] match;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    // With full forwarding only a load still in EX cannot be bypassed.
    assign in_win[k] = (FWD_EN == FWD_FULL) ? ((k == 0) && slots[k].ld)
                                            : ((k < DEPTH-1) || (RF_BYPASS == 0));
    assign match[k]  = slots[k].v && (slots[k].rd == src) && in_win[k];
  end

  assign hit = src_vld & (|match);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side register scoreboard: tracks in-flight destinations from EX to WB,
// stalls decode on RAW hazards, kills wrong-path slots on flush and counts stall cycles.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int DEPTH       = 3,
  parameter int FWD_EN      = FWD_NONE,
  parameter int RF_BYPASS   = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16,
  localparam int RW         = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                id_rs_vld,
  input  logic [RW-1:0]       id_rs,
  input  logic                id_rt_vld,
  input  logic [RW-1:0]       id_rt,
  input  logic                id_wr,
  input  logic [RW-1:0]       id_rd,
  input  logic                id_load,
  input  logic                flush,
  input  logic                ext_stall,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int NUM_SRC = 2;

  sb_entry_t [DEPTH-1:0]   slot_q, slot_d;
  logic [NUM_REGS-1:0]     busy_d;
  logic [NUM_SRC-1:0]      src_vld;
  sb_rd_t [NUM_SRC-1:0]    src;
  logic [NUM_SRC-1:0]      hit;
  logic                    haz;

  assign src_vld[0] = id_rs_vld;
  assign src_vld[1] = id_rt_vld;
  assign src[0]     = sb_rd_t'(id_rs);
  assign src[1]     = sb_rd_t'(id_rt);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    sb_match #(
      .DEPTH     (DEPTH),
      .FWD_EN    (FWD_EN),
      .RF_BYPASS (RF_BYPASS)
    ) u_match (
      .src_vld (src_vld[g]),
      .src     (src[g]),
      .slots   (slot_q),
      .hit     (hit[g])
    );
  end

  assign haz   = id_valid & (|hit);
  assign stall = ext_stall | haz;
  assign issue = id_valid & ~stall & ~flush;

  // A stalled or flushed decode still advances older slots; slot 0 takes a bubble.
  always_comb begin
    slot_d = slot_q;
    if (!ext_stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        slot_d[k] = slot_q[k-1];
        if (flush && (k < FLUSH_DEPTH)) slot_d[k].v = 1'b0;
      end
      slot_d[0] = '{v: issue & id_wr, rd: sb_rd_t'(id_rd), ld: id_load};
    end
  end

  always_comb begin
    busy_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_d[k].v) busy_d[slot_d[k].rd[RW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q    <= '0;
      busy_mask <= '0;
      stall_cnt <= '0;
    end else begin
      slot_q    <= slot_d;
      busy_mask <= busy_d;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives three scoreboard configurations with shared stimulus and checks them
// against an age-queue model of in-flight writes.
module tb_hazard_scoreboard;

  localparam int NC = 3;
  localparam int DEP [NC] = '{3, 4, 4};
  localparam int FWD [NC] = '{0, 1, 0};
  localparam int BYP [NC] = '{1, 1, 0};
  localparam int FDP [NC] = '{1, 2, 2};
  localparam int CNW [NC] = '{16, 16, 4};

  typedef struct { int rd; bit ld; int age; } ent_t;
  typedef struct {
    bit [NC-1:0] chk, st, is;
    int          busy [NC];
    int          cnt  [NC];
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 0, id_rs_vld = 0, id_rt_vld = 0, id_wr = 0, id_load = 0, flush = 0, ext_stall = 0;
  logic [3:0] rs4 = '0, rt4 = '0, rd4 = '0;
  logic [NC-1:0] d_st, d_is;
  logic [7:0]  busy0, busy2;
  logic [15:0] busy1, cnt0, cnt1;
  logic [3:0]  cnt2;

  ent_t pend [NC][$];
  int   mcnt [NC];
  exp_t q [$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(8), .DEPTH(3), .FWD_EN(0), .RF_BYPASS(1), .FLUSH_DEPTH(1), .CNT_W(16)) u_c0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_vld(id_rs_vld), .id_rs(rs4[2:0]),
    .id_rt_vld(id_rt_vld), .id_rt(rt4[2:0]), .id_wr(id_wr), .id_rd(rd4[2:0]), .id_load(id_load),
    .flush(flush), .ext_stall(ext_stall), .stall(d_st[0]), .issue(d_is[0]), .busy_mask(busy0), .stall_cnt(cnt0));

  hazard_scoreboard #(.NUM_REGS(16), .DEPTH(4), .FWD_EN(1), .RF_BYPASS(1), .FLUSH_DEPTH(2), .CNT_W(16)) u_c1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_vld(id_rs_vld), .id_rs(rs4),
    .id_rt_vld(id_rt_vld), .id_rt(rt4), .id_wr(id_wr), .id_rd(rd4), .id_load(id_load),
    .flush(flush), .ext_stall(ext_stall), .stall(d_st[1]), .issue(d_is[1]), .busy_mask(busy1), .stall_cnt(cnt1));

  hazard_scoreboard #(.NUM_REGS(8), .DEPTH(4), .FWD_EN(0), .RF_BYPASS(0), .FLUSH_DEPTH(2), .CNT_W(4)) u_c2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_vld(id_rs_vld), .id_rs(rs4[2:0]),
    .id_rt_vld(id_rt_vld), .id_rt(rt4[2:0]), .id_wr(id_wr), .id_rd(rd4[2:0]), .id_load(id_load),
    .flush(flush), .ext_stall(ext_stall), .stall(d_st[2]), .issue(d_is[2]), .busy_mask(busy2), .stall_cnt(cnt2));

  // A pending write blocks a reader while its age is inside the window the mode allows.
  function automatic bit in_window(int c, ent_t e);
    if (FWD[c] != 0) return (e.age == 0) && e.ld;
    return (e.age <= DEP[c] - 2) || (BYP[c] == 0 && e.age == DEP[c] - 1);
  endfunction

  function automatic bit src_haz(int c, bit sv, int s);
    if (!sv) return 1'b0;
    foreach (pend[c][i]) if (pend[c][i].rd == s && in_window(c, pend[c][i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int busy_of(int c);
    int m = 0;
    foreach (pend[c][i]) m |= (1 << pend[c][i].rd);
    return m;
  endfunction

  task automatic check(string nm, int c, int got, int want);
    if (got != want) begin
      n_err++;
      $display("FAIL cfg%0d %s got=%0h want=%0h", c, nm, got, want);
    end
  endtask

  task automatic apply(bit r, bit iv, bit rsv, int rs, bit rtv, int rt, bit wr, int rd, bit ld, bit fl, bit ex);
    exp_t e;
    @(posedge clk); #2;
    rst = r; id_valid = iv; id_rs_vld = rsv; rs4 = 4'(rs); id_rt_vld = rtv; rt4 = 4'(rt);
    id_wr = wr; rd4 = 4'(rd); id_load = ld; flush = fl; ext_stall = ex;
    for (int c = 0; c < NC; c++) begin
      bit h, st, is;
      ent_t nq [$];
      h  = iv && (src_haz(c, rsv, rs) || src_haz(c, rtv, rt));
      st = ex || h;
      is = iv && !st && !fl;
      e.chk[c] = r; e.st[c] = st; e.is[c] = is;
      if (!r) begin
        pend[c].delete();
        mcnt[c] = 0;
      end else begin
        if (st && mcnt[c] < (1 << CNW[c]) - 1) mcnt[c]++;
        if (!ex) begin
          foreach (pend[c][i]) begin
            ent_t x = pend[c][i];
            x.age++;
            if (x.age < DEP[c] && !(fl && x.age < FDP[c])) nq.push_back(x);
          end
          if (is && wr) nq.push_back('{rd: rd, ld: ld, age: 0});
          pend[c] = nq;
        end
      end
      e.busy[c] = busy_of(c);
      e.cnt[c]  = mcnt[c];
    end
    q.push_back(e);
  endtask

  // Monitor: comb outputs mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    logic [NC-1:0] s_st, s_is;
    forever begin
      @(negedge clk);
      if (q.size() == 0) continue;
      s_st = d_st; s_is = d_is;
      @(posedge clk); #1;
      e = q.pop_front();
      n_vec++;
      for (int c = 0; c < NC; c++) begin
        if (e.chk[c]) begin
          check("stall", c, int'(s_st[c]), int'(e.st[c]));
          check("issue", c, int'(s_is[c]), int'(e.is[c]));
        end
      end
      check("busy_mask", 0, int'(busy0), e.busy[0]);
      check("busy_mask", 1, int'(busy1), e.busy[1]);
      check("busy_mask", 2, int'(busy2), e.busy[2]);
      check("stall_cnt", 0, int'(cnt0), e.cnt[0]);
      check("stall_cnt", 1, int'(cnt1), e.cnt[1]);
      check("stall_cnt", 2, int'(cnt2), e.cnt[2]);
    end
  end

  task automatic idle(int n);
    repeat (n) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ADD r1 then SUB reading r1, held until it issues
    apply(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    repeat (3) apply(1, 1, 1, 1, 0, 0, 1, 2, 0, 0, 0);
    idle(4);
    // load-use and ALU-use
    apply(1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
    repeat (3) apply(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    repeat (2) apply(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    idle(4);
    // producer r4, gap, consumer
    apply(1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    idle(1);
    repeat (3) apply(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // r5, r6 writers then flush, then consumer of r6
    apply(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    apply(1, 1, 1, 7, 0, 0, 1, 0, 0, 1, 0);
    repeat (2) apply(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // freeze with r7 in slot 0, flush during freeze
    apply(1, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    repeat (2) apply(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) apply(1, 1, 1, 7, 0, 0, 0, 0, 0, 1, 1);
    idle(5);
    // two sources on two different producers
    apply(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    repeat (4) apply(1, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
    // mid-stream reset with r1/r2/r3 in flight
    apply(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    apply(0, 1, 1, 3, 0, 0, 1, 4, 0, 0, 0);
    idle(2);
    // counter saturation on the narrow counter
    repeat (20) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int n = 0; n < 1500; n++) begin
      int sel = $urandom_range(0, 9);
      apply($urandom_range(0, 99) >= 2,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 7, (sel < 7) ? $urandom_range(0, 3) : $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 9) < 7, (sel < 7) ? $urandom_range(0, 3) : $urandom_range(0, 7),
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0);
    end
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
